// File: rtl/snn_pkg.sv
// rtl/snn_pkg.sv - shared SNN sizing parameters and scheduler state type
package snn_pkg;

    localparam int N_PE   = 16;
    localparam int N_IN   = 16;
    localparam int ADDR_W = $clog2(N_IN * N_PE);
    localparam int IN_W   = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int IDX_W  = (N_PE > 1) ? $clog2(N_PE) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_DRAIN = 3'd2,
        S_ACCUM = 3'd3,
        S_STEP  = 3'd4
    } sched_state_t;

    function automatic bit is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

endpackage

// File: rtl/event_scheduler_if.sv
// rtl/event_scheduler_if.sv - event, weight-memory and PE-array signals of the scheduler
interface event_scheduler_if;
    import snn_pkg::*;

    logic              event_valid;
    logic [IN_W-1:0]   event_addr;
    logic              event_ready;
    logic              timestep_end;
    logic [ADDR_W-1:0] weight_raddr;
    logic [N_PE-1:0]   weight_pe_w_en;
    logic              accum_en;
    logic              spike_done;
    logic              busy;
    logic [15:0]       event_count;

    // Sensor/timestep side: drives events, observes the scheduler
    modport master (
        output event_valid, event_addr, timestep_end,
        input  event_ready, weight_raddr, weight_pe_w_en, accum_en,
               spike_done, busy, event_count
    );

    // Scheduler side
    modport slave (
        input  event_valid, event_addr, timestep_end,
        output event_ready, weight_raddr, weight_pe_w_en, accum_en,
               spike_done, busy, event_count
    );

endinterface

// File: rtl/event_scheduler.sv
// rtl/event_scheduler.sv - sequences weight fetch, PE load, accumulate and timestep close
module event_scheduler
    import snn_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    event_scheduler_if.slave  bus
);

    generate
        if (!is_pow2(N_PE) || (N_IN < 1)) begin : g_param_check
            $error("event_scheduler: N_PE must be a power of 2 and N_IN >= 1");
        end
    endgenerate

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PE - 1);

    sched_state_t      state;
    sched_state_t      state_nxt;
    logic [IDX_W-1:0]  j_q;
    logic [IN_W-1:0]   addr_q;
    logic              pipe_valid;
    logic [IDX_W-1:0]  pipe_idx;
    logic              step_pending;
    logic [15:0]       event_count_q;

    logic              ready_c;
    logic [ADDR_W-1:0] raddr_c;
    logic              accum_c;
    logic              spike_c;
    logic              accept;

    // Next-state and per-state strobes
    always_comb begin
        state_nxt = state;
        ready_c   = 1'b0;
        raddr_c   = '0;
        accum_c   = 1'b0;
        spike_c   = 1'b0;
        case (state)
            S_IDLE: begin
                ready_c = !step_pending && !bus.timestep_end;
                if (step_pending || bus.timestep_end) begin
                    state_nxt = S_STEP;
                end else if (bus.event_valid) begin
                    state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                raddr_c = ADDR_W'({addr_q, j_q});
                if (j_q == LAST_IDX) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Wait for the final weight to leave the read pipeline
                if (pipe_valid && (pipe_idx == LAST_IDX)) begin
                    state_nxt = S_ACCUM;
                end
            end
            S_ACCUM: begin
                accum_c   = 1'b1;
                state_nxt = S_IDLE;
            end
            S_STEP: begin
                spike_c   = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign accept = (state == S_IDLE) && bus.event_valid && ready_c;

    // State register
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Weight index, latched event address and the 1-cycle memory read pipeline
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            j_q        <= '0;
            addr_q     <= '0;
            pipe_valid <= 1'b0;
            pipe_idx   <= '0;
        end else begin
            if (accept) begin
                j_q    <= '0;
                addr_q <= bus.event_addr;
            end else if (state == S_FETCH) begin
                j_q <= j_q + 1'b1;
            end
            pipe_valid <= (state == S_FETCH);
            pipe_idx   <= j_q;
        end
    end

    // Deferred timestep close and per-timestep event counter
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            step_pending  <= 1'b0;
            event_count_q <= '0;
        end else begin
            if (state == S_STEP) begin
                // A pulse landing on the STEP cycle itself opens a new pending close
                step_pending <= bus.timestep_end;
            end else if ((state != S_IDLE) && bus.timestep_end) begin
                step_pending <= 1'b1;
            end
            if (state == S_STEP) begin
                event_count_q <= '0;
            end else if (accept && (event_count_q != 16'hFFFF)) begin
                event_count_q <= event_count_q + 16'd1;
            end
        end
    end

    // Outputs are forced low while reset is held
    assign bus.event_ready    = reset_n && ready_c;
    assign bus.weight_raddr   = reset_n ? raddr_c : '0;
    assign bus.weight_pe_w_en = (reset_n && pipe_valid) ? (N_PE'(1) << pipe_idx) : '0;
    assign bus.accum_en       = reset_n && accum_c;
    assign bus.spike_done     = reset_n && spike_c;
    assign bus.busy           = reset_n && (state != S_IDLE);
    assign bus.event_count    = reset_n ? event_count_q : 16'd0;

endmodule

// File: tb/tb_event_scheduler.sv
// tb/tb_event_scheduler.sv - directed self-checking bench for event_scheduler
module tb_event_scheduler;
    import snn_pkg::*;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    bit   mon_on = 1'b0;

    always #5 clock = ~clock;

    event_scheduler_if bus ();

    event_scheduler dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Strobe invariants every cycle
    always @(negedge clock) begin
        if (mon_on) begin
            chk("onehot0_w_en", 32'($onehot0(bus.weight_pe_w_en)), 32'd1);
            chk("strobe_excl",
                32'((int'(|bus.weight_pe_w_en) + int'(bus.accum_en) + int'(bus.spike_done)) <= 1),
                32'd1);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        bus.event_valid = 1'b0;
        bus.timestep_end = 1'b0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    // Runs one event from handshake (cycle 0) through cycle 18; returns at cycle 19
    task automatic do_event(input logic [3:0] a, input int ts_a, input int ts_b,
                            input bit keep, output int waited);
        logic [31:0] exp_w;
        bus.event_valid = 1'b1;
        bus.event_addr  = a;
        waited = 0;
        @(negedge clock);
        while (!bus.event_ready && waited < 60) begin
            step();
            @(negedge clock);
            waited++;
        end
        chk("hs_ready", 32'(bus.event_ready), 32'd1);
        step();
        if (!keep) bus.event_valid = 1'b0;
        for (int c = 1; c <= 18; c++) begin
            bus.timestep_end = (c == ts_a) || (c == ts_b);
            @(negedge clock);
            exp_w = (c >= 2 && c <= 17) ? (32'd1 << (c - 2)) : 32'd0;
            chk($sformatf("raddr_c%0d", c), 32'(bus.weight_raddr),
                (c <= 16) ? 32'(int'(a) * 16 + c - 1) : 32'd0);
            chk($sformatf("w_en_c%0d", c), 32'(bus.weight_pe_w_en), exp_w);
            chk($sformatf("accum_c%0d", c), 32'(bus.accum_en), 32'(c == 18));
            chk($sformatf("ready_c%0d", c), 32'(bus.event_ready), 32'd0);
            chk($sformatf("spike_c%0d", c), 32'(bus.spike_done), 32'd0);
            chk($sformatf("busy_c%0d", c), 32'(bus.busy), 32'd1);
            step();
        end
        bus.timestep_end = 1'b0;
    endtask

    initial begin
        int w;
        int n;
        int seen;
        bus.event_valid  = 1'b1;
        bus.event_addr   = '0;
        bus.timestep_end = 1'b0;

        // Reset state: all outputs low even with event_valid high
        @(negedge clock);
        chk("rst_ready", 32'(bus.event_ready), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_count", 32'(bus.event_count), 32'd0);
        chk("rst_w_en", 32'(bus.weight_pe_w_en), 32'd0);
        chk("rst_raddr", 32'(bus.weight_raddr), 32'd0);
        do_reset();
        mon_on = 1'b1;

        // 1: single event addr=1
        do_event(4'd1, 0, 0, 1'b0, w);
        chk("t1_wait", 32'(w), 32'd0);
        @(negedge clock);
        chk("t1_ready19", 32'(bus.event_ready), 32'd1);
        chk("t1_busy19", 32'(bus.busy), 32'd0);
        chk("t1_count", 32'(bus.event_count), 32'd1);
        step();

        // 2: back-to-back with event_valid held
        do_reset();
        do_event(4'd0, 0, 0, 1'b1, w);
        bus.event_addr = 4'd3;
        do_event(4'd3, 0, 0, 1'b0, w);
        chk("t2_second_hs_at_19", 32'(w), 32'd0);
        @(negedge clock);
        chk("t2_count", 32'(bus.event_count), 32'd2);
        step();

        // 3: timestep_end during fetch of addr 2
        do_event(4'd2, 5, 0, 1'b0, w);
        @(negedge clock);
        chk("t3_ready19", 32'(bus.event_ready), 32'd0);
        chk("t3_count19", 32'(bus.event_count), 32'd3);
        step();
        @(negedge clock);
        chk("t3_spike20", 32'(bus.spike_done), 32'd1);
        step();
        @(negedge clock);
        chk("t3_spike21", 32'(bus.spike_done), 32'd0);
        chk("t3_count21", 32'(bus.event_count), 32'd0);
        chk("t3_ready21", 32'(bus.event_ready), 32'd1);
        step();

        // 4: timestep_end and event_valid in the same IDLE cycle
        bus.timestep_end = 1'b1;
        bus.event_valid  = 1'b1;
        bus.event_addr   = 4'd5;
        @(negedge clock);
        chk("t4_ready_blocked", 32'(bus.event_ready), 32'd0);
        step();
        bus.timestep_end = 1'b0;
        @(negedge clock);
        chk("t4_spike", 32'(bus.spike_done), 32'd1);
        chk("t4_ready_in_step", 32'(bus.event_ready), 32'd0);
        step();
        do_event(4'd5, 0, 0, 1'b0, w);
        chk("t4_wait", 32'(w), 32'd0);
        @(negedge clock);
        chk("t4_count", 32'(bus.event_count), 32'd1);
        step();

        // 6: two timestep_end pulses 3 cycles apart merge into one spike_done
        do_event(4'd7, 4, 7, 1'b0, w);
        n = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            if (bus.spike_done) n++;
            step();
        end
        chk("t6_spike_pulses", 32'(n), 32'd1);
        @(negedge clock);
        chk("t6_count", 32'(bus.event_count), 32'd0);
        step();

        // 5: reset mid-fetch at j=7
        bus.event_valid = 1'b1;
        bus.event_addr  = 4'd4;
        @(negedge clock);
        chk("t5_hs_ready", 32'(bus.event_ready), 32'd1);
        step();
        bus.event_valid = 1'b0;
        repeat (7) step();
        @(negedge clock);
        chk("t5_raddr_j7", 32'(bus.weight_raddr), 32'd71);
        reset_n = 1'b0;
        step();
        @(negedge clock);
        chk("t5_rst_raddr", 32'(bus.weight_raddr), 32'd0);
        chk("t5_rst_w_en", 32'(bus.weight_pe_w_en), 32'd0);
        chk("t5_rst_accum", 32'(bus.accum_en), 32'd0);
        chk("t5_rst_busy", 32'(bus.busy), 32'd0);
        chk("t5_rst_count", 32'(bus.event_count), 32'd0);
        step();
        reset_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (bus.accum_en || (|bus.weight_pe_w_en) || bus.busy) seen++;
            step();
        end
        chk("t5_no_strobes_after_rst", 32'(seen), 32'd0);
        do_event(4'd6, 0, 0, 1'b0, w);
        chk("t5_fresh_wait", 32'(w), 32'd0);
        @(negedge clock);
        chk("t5_fresh_ready", 32'(bus.event_ready), 32'd1);
        chk("t5_fresh_count", 32'(bus.event_count), 32'd1);
        step();

        mon_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
